// File: rtl/stepper_pkg.sv
// Shared register map, CTRL bit positions and channel state encoding for
// the APB stepper array.
package stepper_pkg;

  localparam int unsigned MAX_CH = 8;

  // Per-channel register offsets within a 0x10 channel window
  localparam logic [3:0] OFF_STEPS  = 4'h0;
  localparam logic [3:0] OFF_PERIOD = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  // Global registers
  localparam logic [7:0] ADDR_GO       = 8'h80;
  localparam logic [7:0] ADDR_IRQ_STAT = 8'h84;
  localparam logic [7:0] ADDR_IRQ_EN   = 8'h88;

  // CTRL write bits
  localparam int unsigned CTRL_DIR   = 0;
  localparam int unsigned CTRL_START = 1;
  localparam int unsigned CTRL_ABORT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW
  } ch_state_e;

endpackage

// File: rtl/stepper_channel.sv
// One step/direction channel: IDLE -> SETUP -> (HIGH -> LOW)*N -> IDLE.
// done is a single-cycle combinational pulse on the cycle the move ends
// (or on a zero-length start).
module stepper_channel
  import stepper_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DIV_W     = 20,
  parameter int unsigned PULSE_CYC = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dir_in,
  input  logic [CNT_W-1:0] steps_in,
  input  logic [DIV_W-1:0] period_in,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             done
);

  localparam logic [31:0] HIGH_LAST = 32'(PULSE_CYC - 1);
  localparam logic [31:0] MIN_PER   = 32'(PULSE_CYC + 1);

  ch_state_e        state_q, state_d;
  logic [31:0]      tmr_q, tmr_d;
  logic [31:0]      low_len_q, low_len_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic [31:0]      eff_per;

  assign eff_per   = (32'(period_in) < MIN_PER) ? MIN_PER : 32'(period_in);
  assign step      = step_q;
  assign dir       = dir_q;
  assign busy      = (state_q != ST_IDLE);
  assign remaining = rem_q;

  // Timer counts down the cycles left in HIGH/LOW; LOW reload is latched at start.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    low_len_d = low_len_q;
    rem_d     = rem_q;
    step_d    = step_q;
    dir_d     = dir_q;
    done      = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      step_d  = 1'b0;
      rem_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (steps_in == '0) begin
              done = 1'b1;
            end else begin
              state_d   = ST_SETUP;
              rem_d     = steps_in;
              dir_d     = dir_in;
              low_len_d = eff_per - 32'(PULSE_CYC) - 32'd1;
            end
          end
        end
        ST_SETUP: begin
          state_d = ST_HIGH;
          step_d  = 1'b1;
          tmr_d   = HIGH_LAST;
        end
        ST_HIGH: begin
          if (tmr_q == '0) begin
            state_d = ST_LOW;
            step_d  = 1'b0;
            tmr_d   = low_len_q;
          end else begin
            tmr_d = tmr_q - 32'd1;
          end
        end
        ST_LOW: begin
          if (tmr_q == '0) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = ST_IDLE;
              done    = 1'b1;
            end else begin
              state_d = ST_HIGH;
              step_d  = 1'b1;
              tmr_d   = HIGH_LAST;
            end
          end else begin
            tmr_d = tmr_q - 32'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Channel state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      low_len_q <= '0;
      rem_q     <= '0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      low_len_q <= low_len_d;
      rem_q     <= rem_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
    end
  end

endmodule

// File: rtl/apb_stepper_array.sv
// APB3 slave driving NUM_CH stepper channels with a shared GO register.
// Optional done interrupt: define STEPPER_IRQ_EN.
module apb_stepper_array
  import stepper_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DIV_W     = 20,
  parameter int unsigned PULSE_CYC = 50
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] step,
  output logic [NUM_CH-1:0] dir
`ifdef STEPPER_IRQ_EN
  ,
  output logic              irq
`endif
);

  logic [CNT_W-1:0]  steps_q  [NUM_CH];
  logic [CNT_W-1:0]  steps_d  [NUM_CH];
  logic [DIV_W-1:0]  period_q [NUM_CH];
  logic [DIV_W-1:0]  period_d [NUM_CH];
  logic [NUM_CH-1:0] ctrl_dir_q, ctrl_dir_d;
  logic [CNT_W-1:0]  rem [NUM_CH];
  logic [NUM_CH-1:0] busy, done, start, abort;
  logic [NUM_CH-1:0] sel_steps, sel_period, sel_ctrl;
  logic              sel_go;
  logic              acc_err, wr;
  logic [31:0]       rd_data;
  logic [7:0]        addr;
  logic [2:0]        ch_idx;
  logic [3:0]        off;
  logic              ch_ok;
`ifdef STEPPER_IRQ_EN
  logic              sel_stat, sel_en;
  logic [NUM_CH-1:0] irq_stat_q, irq_stat_d, irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
`endif
  logic              unused_bits;

  assign addr        = PADDR[7:0];
  assign ch_idx      = addr[6:4];
  assign off         = {addr[3:2], 2'b00};
  assign ch_ok       = ({29'd0, ch_idx} < 32'(NUM_CH));
  assign wr          = PSEL & PENABLE & PWRITE & ~acc_err;
  assign PRDATA      = PSEL ? rd_data : '0;
  assign PSLVERR     = PSEL & PENABLE & acc_err;
  assign PREADY      = 1'b1;
  assign unused_bits = ^{PADDR[31:8], PADDR[1:0], PWDATA, done};

  // Address decode, error detection and read mux
  always_comb begin
    acc_err    = 1'b0;
    rd_data    = '0;
    sel_steps  = '0;
    sel_period = '0;
    sel_ctrl   = '0;
    sel_go     = 1'b0;
`ifdef STEPPER_IRQ_EN
    sel_stat   = 1'b0;
    sel_en     = 1'b0;
`endif
    if (!addr[7]) begin
      if (!ch_ok || (off == OFF_STATUS && PWRITE)) begin
        acc_err = 1'b1;
      end else begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (ch_idx == 3'(c)) begin
            case (off)
              OFF_STEPS: begin
                sel_steps[c]       = 1'b1;
                rd_data[CNT_W-1:0] = steps_q[c];
              end
              OFF_PERIOD: begin
                sel_period[c]      = 1'b1;
                rd_data[DIV_W-1:0] = period_q[c];
              end
              OFF_CTRL: begin
                sel_ctrl[c]       = 1'b1;
                rd_data[CTRL_DIR] = ctrl_dir_q[c];
              end
              default: begin
                rd_data[0]         = busy[c];
                rd_data[16+:CNT_W] = rem[c];
              end
            endcase
          end
        end
      end
    end else begin
      case (addr)
        ADDR_GO: sel_go = 1'b1;
`ifdef STEPPER_IRQ_EN
        ADDR_IRQ_STAT: begin
          sel_stat            = 1'b1;
          rd_data[NUM_CH-1:0] = irq_stat_q;
        end
        ADDR_IRQ_EN: begin
          sel_en              = 1'b1;
          rd_data[NUM_CH-1:0] = irq_en_q;
        end
`endif
        default: acc_err = 1'b1;
      endcase
    end
  end

  // Register file writes and per-channel start/abort strobes.
  // The channel latches the CTRL.dir being written, so start+dir in one write uses the new dir.
  always_comb begin
    steps_d    = steps_q;
    period_d   = period_q;
    ctrl_dir_d = ctrl_dir_q;
    start      = '0;
    abort      = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (wr && sel_steps[c])  steps_d[c]  = PWDATA[CNT_W-1:0];
      if (wr && sel_period[c]) period_d[c] = PWDATA[DIV_W-1:0];
      if (wr && sel_ctrl[c]) begin
        ctrl_dir_d[c] = PWDATA[CTRL_DIR];
        start[c]      = PWDATA[CTRL_START];
        abort[c]      = PWDATA[CTRL_ABORT];
      end
      if (wr && sel_go && PWDATA[c]) start[c] = 1'b1;
    end
  end

  // Register file state
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      steps_q    <= '{default: '0};
      period_q   <= '{default: '0};
      ctrl_dir_q <= '0;
    end else begin
      steps_q    <= steps_d;
      period_q   <= period_d;
      ctrl_dir_q <= ctrl_dir_d;
    end
  end

`ifdef STEPPER_IRQ_EN
  // A new done takes priority over a same-cycle W1C clear
  always_comb begin
    irq_stat_d = (irq_stat_q & ~((wr && sel_stat) ? PWDATA[NUM_CH-1:0] : '0)) | done;
    irq_en_d   = (wr && sel_en) ? PWDATA[NUM_CH-1:0] : irq_en_q;
    irq_d      = |(irq_stat_q & irq_en_q);
  end

  // Interrupt state
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_stat_q <= irq_stat_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    stepper_channel #(
      .CNT_W    (CNT_W),
      .DIV_W    (DIV_W),
      .PULSE_CYC(PULSE_CYC)
    ) u_ch (
      .clk      (PCLK),
      .rst_n    (PRESERN),
      .start    (start[c]),
      .abort    (abort[c]),
      .dir_in   (ctrl_dir_d[c]),
      .steps_in (steps_q[c]),
      .period_in(period_q[c]),
      .step     (step[c]),
      .dir      (dir[c]),
      .busy     (busy[c]),
      .remaining(rem[c]),
      .done     (done[c])
    );
  end

endmodule
